// File: rtl/image_writer.sv
// Frame capture stage: accepts one frame of pixels on a valid/ready stream and
// writes it sequentially into image memory from address 0, checking frame length.
module image_writer #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int MEM_SIZE   = 76800
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   pixelCount,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [BIT_DEPTH-1:0]  inData,
    input  logic                  inLast,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeAddr,
    output logic [BIT_DEPTH-1:0]  writeData
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 32'sd1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = ADDR_WIDTH'(32'd1);
    localparam logic [ADDR_WIDTH:0]   COUNT_INC = (ADDR_WIDTH + 1)'(32'd1);

    state_t                state_r;
    state_t                state_s;
    logic                  beat_s;
    logic                  at_end_s;
    logic                  frame_end_s;
    logic                  frame_err_s;
    logic                  capture_start_s;

    logic [ADDR_WIDTH-1:0] pixel_addr_r;
    logic [ADDR_WIDTH:0]   pixel_count_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic                  in_ready_r;
    logic                  write_enable_r;
    logic [ADDR_WIDTH-1:0] write_addr_r;
    logic [BIT_DEPTH-1:0]  write_data_r;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and frame-end classification on the accepted beat
    always_comb begin
        state_s         = state_r;
        at_end_s        = (pixel_addr_r == LAST_ADDR);
        beat_s          = (state_r == ST_WRITE) && inValid;
        capture_start_s = (state_r == ST_IDLE) && start;
        frame_end_s     = 1'b0;
        frame_err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // A full frame must end exactly on its last address; any other ending is an error
                if (beat_s && (at_end_s || inLast)) begin
                    frame_end_s = 1'b1;
                    frame_err_s = at_end_s ^ inLast;
                    state_s     = ST_FINISH;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Status flags, decoded one cycle early so they align with the state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            busy_r     <= (state_s == ST_WRITE);
            in_ready_r <= (state_s == ST_WRITE);
            done_r     <= frame_end_s;
            if (capture_start_s) begin
                error_r <= 1'b0;
            end else if (frame_err_s) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
        end
    end

    // Pixel address/count and the registered memory write port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_addr_r   <= '0;
            pixel_count_r  <= '0;
            write_enable_r <= 1'b0;
            write_addr_r   <= '0;
            write_data_r   <= '0;
        end else begin
            write_enable_r <= beat_s;
            if (capture_start_s) begin
                pixel_addr_r  <= '0;
                pixel_count_r <= '0;
            end else if (beat_s) begin
                write_addr_r  <= pixel_addr_r;
                write_data_r  <= inData;
                pixel_count_r <= pixel_count_r + COUNT_INC;
                // Hold on the last address so the pointer can never wrap
                if (!at_end_s) begin
                    pixel_addr_r <= pixel_addr_r + ADDR_INC;
                end else begin
                    pixel_addr_r <= pixel_addr_r;
                end
            end else begin
                pixel_addr_r  <= pixel_addr_r;
                pixel_count_r <= pixel_count_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign pixelCount  = pixel_count_r;
    assign inReady     = in_ready_r;
    assign writeEnable = write_enable_r;
    assign writeAddr   = write_addr_r;
    assign writeData   = write_data_r;

endmodule

// File: tb/tb_image_writer.sv
// Self-checking bench for image_writer with a 16-pixel frame: table of frame cases,
// randomized frames against a scoreboard, plus reset and abort sequences.
module tb_image_writer;

    localparam int BD  = 8;
    localparam int AW  = 5;
    localparam int MS  = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   pixelCount;
    logic          inValid;
    logic          inReady;
    logic [BD-1:0] inData;
    logic          inLast;
    logic          writeEnable;
    logic [AW-1:0] writeAddr;
    logic [BD-1:0] writeData;

    int tests  = 0;
    int failed = 0;

    image_writer #(.BIT_DEPTH(BD), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .error(error), .pixelCount(pixelCount), .inValid(inValid), .inReady(inReady),
        .inData(inData), .inLast(inLast), .writeEnable(writeEnable),
        .writeAddr(writeAddr), .writeData(writeData)
    );

    always #5 clock = ~clock;

    typedef struct {
        int last_at;
        int gap_pct;
        int exp_n;
        bit exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One frame: last_at = 1-based position of inLast (0 or >16 means never)
    task automatic run_frame(input int last_at, input int gap_pct, input int exp_n, input bit exp_err);
        int  k;
        int  cyc;
        int  dones;
        bit  ended;
        bit  want_beat;
        bit  exp_done;
        logic [BD-1:0] exp_data;
        start = 1'b1; inValid = 1'b0; inLast = 1'b0;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", inReady, 1);
        check("start_err_clr", error, 0);
        check("start_count_clr", pixelCount, 0);
        check("start_no_we", writeEnable, 0);
        k = 0; cyc = 0; dones = 0; ended = 1'b0;
        while (!ended && cyc < 200) begin
            cyc++;
            inValid  = ($urandom_range(0, 99) >= gap_pct);
            inData   = BD'($urandom);
            inLast   = inValid ? (k + 1 == last_at) : 1'($urandom_range(0, 1));
            start    = ($urandom_range(0, 7) == 0);
            want_beat = inValid;
            exp_data = inData;
            tick();
            check("we", writeEnable, want_beat);
            exp_done = 1'b0;
            if (want_beat) begin
                check("waddr", writeAddr, k);
                check("wdata", writeData, exp_data);
                exp_done = (k == MS - 1) || (k + 1 == last_at);
                k++;
            end
            check("done", done, exp_done);
            if (done) dones++;
            ended = exp_done;
            if (!ended) begin
                check("ready_mid", inReady, 1);
                check("busy_mid", busy, 1);
            end
        end
        if (!ended) begin
            tests++;
            failed++;
            $display("FAIL frame_timeout: got %0d beats expected frame end", k);
        end
        check("n_writes", k, exp_n);
        check("done_once", dones, 1);
        check("end_error", error, exp_err);
        check("end_count", pixelCount, exp_n);
        check("end_busy", busy, 0);
        check("end_ready", inReady, 0);
        // start during the finish cycle and further pixels must both be ignored
        start = 1'b1; inValid = 1'b1; inLast = 1'b0;
        tick();
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("post_we", writeEnable, 0);
            check("post_ready", inReady, 0);
            check("post_busy", busy, 0);
            check("post_done", done, 0);
            check("post_count", pixelCount, exp_n);
            check("post_error", error, exp_err);
            tick();
        end
        inValid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{last_at: 16, gap_pct: 0,  exp_n: 16, exp_err: 1'b0};
        vecs[1] = '{last_at: 5,  gap_pct: 0,  exp_n: 5,  exp_err: 1'b1};
        vecs[2] = '{last_at: 0,  gap_pct: 0,  exp_n: 16, exp_err: 1'b1};
        vecs[3] = '{last_at: 16, gap_pct: 40, exp_n: 16, exp_err: 1'b0};
        vecs[4] = '{last_at: 1,  gap_pct: 20, exp_n: 1,  exp_err: 1'b1};
        vecs[5] = '{last_at: 15, gap_pct: 30, exp_n: 15, exp_err: 1'b1};
        vecs[6] = '{last_at: 17, gap_pct: 10, exp_n: 16, exp_err: 1'b1};
        vecs[7] = '{last_at: 16, gap_pct: 60, exp_n: 16, exp_err: 1'b0};

        // Reset with stimulus active
        reset = 1'b0; start = 1'b1; inValid = 1'b1; inData = 8'hAA; inLast = 1'b1;
        tick(); tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_count", pixelCount, 0);
        check("rst_ready", inReady, 0);
        check("rst_we", writeEnable, 0);
        check("rst_waddr", writeAddr, 0);
        check("rst_wdata", writeData, 0);
        reset = 1'b1; start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("idle_ready", inReady, 0);
            check("idle_we", writeEnable, 0);
            check("idle_busy", busy, 0);
        end
        inValid = 1'b0; inLast = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].last_at, vecs[v].gap_pct, vecs[v].exp_n, vecs[v].exp_err);
        end

        // Abort mid-frame by reset, then recover
        run_frame(3, 0, 3, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0; inValid = 1'b1; inLast = 1'b0;
        for (int j = 0; j < 7; j++) begin
            inData = BD'(8'h40 + j);
            tick();
            check("abort_we", writeEnable, 1);
            check("abort_waddr", writeAddr, j);
        end
        #3 reset = 1'b0;
        #1;
        check("abort_rst_we", writeEnable, 0);
        check("abort_rst_ready", inReady, 0);
        check("abort_rst_count", pixelCount, 0);
        check("abort_rst_error", error, 0);
        tick(); tick();
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("abort_idle_we", writeEnable, 0);
            check("abort_idle_ready", inReady, 0);
        end
        inValid = 1'b0;
        run_frame(5, 0, 5, 1'b1);
        run_frame(16, 0, 16, 1'b0);

        // Randomized frames against the scoreboard
        for (int r = 0; r < 12; r++) begin
            int la;
            la = $urandom_range(0, 18);
            run_frame(la, $urandom_range(0, 60), (la >= 1 && la <= MS) ? la : MS, la != MS);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
